// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-code helpers for the async FIFO read/write controllers.
package fifo_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    // Helpers work on a zero-extended 32-bit pointer so any ADDR_W+1 width fits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read controller: pointer/empty tracking plus a 2-entry FWFT output buffer
// that hides the one-cycle RAM read latency.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = fifo_pkg::ADDR_W,
    parameter int unsigned DATA_W = fifo_pkg::DATA_W
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W:0]   rptr_gray,
    output logic [ADDR_W-1:0] raddr,
    output logic              rclken,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              rempty,
    output logic [ADDR_W:0]   rlevel
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  wq2;
    logic [PTR_W-1:0]  rbin_q, rbin_d;
    logic [PTR_W-1:0]  rptr_gray_q, rgray_d;
    logic [PTR_W-1:0]  rlevel_q, wbin;
    logic              rempty_q;
    logic              inflight_q;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic              pop;
    logic [2:0]        fill;

    sync_2ff #(
        .WIDTH (PTR_W)
    ) u_wsync (
        .rclk (rclk),
        .rrst (rrst),
        .d    (wptr_gray),
        .q    (wq2)
    );

    assign dout_valid = (occ_q != 2'd0);
    assign pop        = dout_valid & dout_ready;

    // Slots committed after this edge: buffered + returning - leaving.
    assign fill    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign rclken  = !rempty_q && (fill < 3'd2);
    assign rbin_d  = rbin_q + PTR_W'(rclken);
    assign rgray_d = PTR_W'(bin2gray(32'(rbin_d)));
    assign wbin    = PTR_W'(gray2bin(32'(wq2)));

    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        unique case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = rdata;
                else               buf1_d = rdata;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = rdata;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            rempty_q    <= 1'b1;
            rlevel_q    <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_gray_q <= rgray_d;
            rempty_q    <= (rgray_d == wq2);
            rlevel_q    <= wbin - rbin_d;
            inflight_q  <= rclken;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

    // Issue throttling guarantees a returning word always has a free slot.
    a_no_overflow: assert property (@(posedge rclk) disable iff (rrst)
        !(inflight_q && (occ_q == 2'd2) && !pop));

    assign rptr_gray = rptr_gray_q;
    assign raddr     = rbin_q[ADDR_W-1:0];
    assign dout      = buf0_q;
    assign rempty    = rempty_q;
    assign rlevel    = rlevel_q;

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the async FIFO, on the opposite end of the dual-port RAM from the write controller. It runs entirely in the read clock domain and synchronizes the write pointer from the write side. It drives raddr/rclken into the RAM and computes the Gray read pointer and the empty flag. A 2-entry first-word-fall-through output buffer with valid/ready hides the 1-cycle RAM read latency.

Parameters:
ADDR_W, 8, RAM address width; FIFO depth = 2**ADDR_W
DATA_W, 8, RAM data width

Ports:
rclk  in  1  read-domain clock; all state on rising edge
rrst  in  1  reset, asynchronous, active-high
wptr_gray  in  ADDR_W+1  Gray write pointer from write domain; asynchronous to rclk
rptr_gray  out  ADDR_W+1  Gray read pointer, registered, to write domain
raddr  out  ADDR_W  RAM read address = rbin[ADDR_W-1:0]
rclken  out  1  RAM read enable
rdata  in  DATA_W  RAM read data, valid 1 rclk after rclken
dout  out  DATA_W  head word of the output buffer
dout_valid  out  1  head word present
dout_ready  in  1  consumer accepts head; pop = dout_valid & dout_ready
rempty  out  1  no unread words remain in RAM (registered)
rlevel  out  ADDR_W+1  words in RAM not yet fetched, as seen after synchronization

Behaviour:
- Interface: one clock, rclk; reset rrst is asynchronous and active-high.
- Reset values: rbin=0, rptr_gray=0, wq1/wq2=0, rempty=1, rclken=0, dout_valid=0, dout=0, buffer occupancy=0, inflight=0, rlevel=0.
- Synchronizer: wptr_gray passes through two flops, wq1 then wq2. Only wq2 is used.
- Read issue: rclken = !rempty & (occ + inflight - pop < 2). occ is 0..2 and inflight is 0..1.
- On issue: rbin <= rbin+1, which wraps modulo 2**(ADDR_W+1). raddr wraps from 2**ADDR_W-1 to 0.
- Gray pointer: rptr_gray <= rbin_next ^ (rbin_next>>1).
- rempty <= (gray(rbin_next) == wq2). The flag is pessimistic: it deasserts 3 rclk after a wptr_gray change at the earliest.
- Return path: inflight <= rclken. When inflight=1, rdata is written into the buffer tail in that cycle.
- Buffer is a 2-entry FIFO, in order:
  - dout shows the head; dout_valid = (occ != 0).
  - Push and pop in the same cycle are legal and keep occ unchanged.
  - Pushing into a full buffer cannot happen by construction. Cover it with an assertion.
- Buffer bypass is not permitted: dout is always a registered value.
- Latency: rclken at cycle t gives dout_valid at t+1 if the buffer was empty.
- Throughput: 1 word/cycle is sustained while dout_ready=1 and the RAM is non-empty.
- Backpressure: dout_ready=0 stops reads after at most 2 words are buffered. dout and dout_valid hold stable while dout_valid & !dout_ready.
- rlevel <= gray2bin(wq2) - rbin_next, modulo 2**(ADDR_W+1). The range is 0..2**ADDR_W.
- wptr_gray stepping more than one Gray code between samples is a write-side error. No recovery is defined.
- Reset mid-operation: all state clears immediately. In-flight RAM data returning after reset is discarded. No read is issued until rrst deasserts and wq2 shows non-empty.

Decomposition:
- Shared include fifo_pkg:
  - ADDR_W/DATA_W defaults
  - functions bin2gray and gray2bin (ADDR_W+1 bits)
- Sub-module sync_2ff (parameter WIDTH; ports rclk, rrst, d, q; reset value 0). The write controller reuses it for the read pointer.
- The output buffer stays inline.

Test Plan:
- Reset: hold rrst=1 for 3 cycles, wptr_gray=0 -> rempty=1, dout_valid=0, raddr=0, rptr_gray=0, rclken=0, rlevel=0.
- Single word:
  - Stimulus: RAM[0]=0xA5, wptr_gray 0->0x001 at edge k, dout_ready=1.
  - Issue: rempty=0 and rclken=1 with raddr=0 at k+3.
  - Delivery: dout=0xA5 and dout_valid=1 at k+4.
  - Final state: rptr_gray=0x001, rempty=1.
- Backpressure:
  - Stimulus: RAM[0..4]=0x10..0x14, wptr=5 (gray 0x007), dout_ready=0.
  - Stall: exactly 2 reads issued, raddr holds at 2, dout stays 0x10.
  - Release: raising dout_ready=1 yields 0x10..0x14 on 5 consecutive cycles, then dout_valid=0.
- Wrap:
  - Stimulus: stream 300 words with dout_ready=1.
  - Address: raddr goes 255 -> 0.
  - Pointer: rptr_gray reaches 0x180 (bin 256).
  - Data: the sequence is unbroken with no duplicates.
- Full level: rbin=0, wptr_gray=0x180 (256 written) -> rlevel=256 after 3 rclk, rempty=0.
- Reset mid-stream:
  - Stimulus: pulse rrst for 1 cycle while inflight=1.
  - Response: dout_valid=0 next cycle and the returned data is dropped.
  - Recovery: reads restart from raddr=0 only after wq2 is non-empty.
